prime_frame_stats: RTL and testbench

Sequential statistics stage placed directly downstream of `prime_detector`. It accepts a stream of 4-bit values, each paired with the detector's prime flag, using a valid/ready handshake. It groups the samples into frames of FRAME_LEN, or shorter when flushed. For each frame it reports the prime count, the longest run of consecutive primes, and the last prime seen, through a valid/ready result port.

---
 rtl/prime_frame_stats_if.sv | 36 +++
 rtl/prime_frame_stats.sv | 137 +++++++++++++
 tb/tb_prime_frame_stats.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prime_frame_stats_if.sv
// Sample/result handshake bundle for prime_frame_stats.
// out_max exists only when PRIME_MAX_EN is defined.
interface prime_frame_stats_if #(
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_value;
   logic             in_prime;
   logic             frame_flush;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] out_count;
   logic [CNT_W-1:0] out_run;
   logic [3:0]       out_last;
   logic [CNT_W-1:0] out_len;
`ifdef PRIME_MAX_EN
   logic [3:0]       out_max;
`endif

   modport master (
      output in_valid, in_value, in_prime, frame_flush, out_ready,
      input  in_ready, out_valid, out_count, out_run, out_last, out_len
`ifdef PRIME_MAX_EN
      , out_max
`endif
   );

   modport slave (
      input  in_valid, in_value, in_prime, frame_flush, out_ready,
      output in_ready, out_valid, out_count, out_run, out_last, out_len
`ifdef PRIME_MAX_EN
      , out_max
`endif
   );
endinterface

// File: rtl/prime_frame_stats.sv
// Per-frame prime statistics (count, longest run, last prime, length) behind prime_detector.
// Optional largest-prime tracking is enabled with PRIME_MAX_EN.
//
// state  | meaning
// ACCUM  | accepting samples, accumulating the current frame
// REPORT | frame result held on the output port until out_ready
module prime_frame_stats #(
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = 4
) (
   input logic               clk,
   input logic               rst_n,
   prime_frame_stats_if.slave bus
);
   typedef enum logic {ACCUM, REPORT} state_t;

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] LEN_END = CNT_W'(FRAME_LEN);

   state_t state_q, state_d;

   logic [CNT_W-1:0] len_q, count_q, cur_q, best_q;
   logic [3:0]       last_q;
   logic [CNT_W-1:0] len_nx, count_nx, cur_nx, best_nx;
   logic [3:0]       last_nx;
   logic [CNT_W-1:0] out_count_q, out_run_q, out_len_q;
   logic [3:0]       out_last_q;
`ifdef PRIME_MAX_EN
   logic [3:0]       max_q, max_nx, out_max_q;
`endif

   logic accept;
   logic close;

   assign accept = bus.in_valid && (state_q == ACCUM);

   always_comb begin
      len_nx   = len_q;
      count_nx = count_q;
      cur_nx   = cur_q;
      best_nx  = best_q;
      last_nx  = last_q;
`ifdef PRIME_MAX_EN
      max_nx   = max_q;
`endif
      if (accept) begin
         len_nx = len_q + ONE;
         if (bus.in_prime) begin
            count_nx = count_q + ONE;
            cur_nx   = cur_q + ONE;
            if (cur_nx > best_q) best_nx = cur_nx;
            last_nx  = bus.in_value;
`ifdef PRIME_MAX_EN
            if (bus.in_value > max_q) max_nx = bus.in_value;
`endif
         end else begin
            cur_nx = '0;
         end
      end
   end

   // A flush with nothing accepted only closes a non-empty frame.
   assign close = (state_q == ACCUM) &&
                  ((accept && (len_nx == LEN_END || bus.frame_flush)) ||
                   (!accept && bus.frame_flush && len_q != '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         ACCUM: begin
            bus.in_ready = 1'b1;
            if (close) state_d = REPORT;
         end
         REPORT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q       <= '0;
         count_q     <= '0;
         cur_q       <= '0;
         best_q      <= '0;
         last_q      <= '0;
         out_count_q <= '0;
         out_run_q   <= '0;
         out_last_q  <= '0;
         out_len_q   <= '0;
`ifdef PRIME_MAX_EN
         max_q       <= '0;
         out_max_q   <= '0;
`endif
      end else if (close) begin
         out_count_q <= count_nx;
         out_run_q   <= best_nx;
         out_last_q  <= last_nx;
         out_len_q   <= len_nx;
         len_q       <= '0;
         count_q     <= '0;
         cur_q       <= '0;
         best_q      <= '0;
         last_q      <= '0;
`ifdef PRIME_MAX_EN
         out_max_q   <= max_nx;
         max_q       <= '0;
`endif
      end else if (accept) begin
         len_q   <= len_nx;
         count_q <= count_nx;
         cur_q   <= cur_nx;
         best_q  <= best_nx;
         last_q  <= last_nx;
`ifdef PRIME_MAX_EN
         max_q   <= max_nx;
`endif
      end
   end

   assign bus.out_count = out_count_q;
   assign bus.out_run   = out_run_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_len   = out_len_q;
`ifdef PRIME_MAX_EN
   assign bus.out_max   = out_max_q;
`endif
endmodule

// File: tb/tb_prime_frame_stats.sv
// Bench for prime_frame_stats: directed test-plan frames plus randomized traffic
// against a frame-queue reference model. Checks out_max when PRIME_MAX_EN is defined.
module tb_prime_frame_stats;
   localparam int FL = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   prime_frame_stats_if #(.CNT_W(CW)) bus ();

   prime_frame_stats #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] v;
      logic       p;
   } samp_t;

   samp_t      frame_q[$];
   bit         m_report;
   logic [3:0] e_count, e_run, e_last, e_len, e_max;
   logic [15:0] snap;

   function automatic bit is_prime(input logic [3:0] x);
      int n = int'(x);
      if (n < 2) return 1'b0;
      for (int d = 2; d * d <= n; d++)
         if (n % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   // Reference statistics computed from the whole stored frame at close time.
   task automatic close_frame();
      int run = 0, cnt = 0, best = 0, last = 0, mx = 0;
      foreach (frame_q[i]) begin
         if (frame_q[i].p) begin
            cnt++;
            run++;
            if (run > best) best = run;
            last = int'(frame_q[i].v);
            if (int'(frame_q[i].v) > mx) mx = int'(frame_q[i].v);
         end else begin
            run = 0;
         end
      end
      e_count = 4'(cnt);
      e_run   = 4'(best);
      e_last  = 4'(last);
      e_max   = 4'(mx);
      e_len   = 4'(frame_q.size());
      frame_q.delete();
      m_report = 1'b1;
   endtask

   task automatic model_reset();
      frame_q.delete();
      m_report = 1'b0;
   endtask

   // One clock: drive inputs away from the edge, clock, then advance the model.
   task automatic cycle(input bit v, input logic [3:0] val, input bit p,
                        input bit fl, input bit ordy);
      bit    acc;
      samp_t s;
      bus.in_valid    = v;
      bus.in_value    = val;
      bus.in_prime    = p;
      bus.frame_flush = fl;
      bus.out_ready   = ordy;
      acc = v && !m_report;
      @(posedge clk);
      #1;
      if (m_report) begin
         if (ordy) m_report = 1'b0;
      end else begin
         if (acc) begin
            s.v = val;
            s.p = p;
            frame_q.push_back(s);
         end
         if ((acc && (frame_q.size() == FL || fl)) || (!acc && fl && frame_q.size() > 0))
            close_frame();
      end
   endtask

   task automatic feed(input logic [3:0] val, input bit ordy);
      cycle(1'b1, val, is_prime(val), 1'b0, ordy);
   endtask

   task automatic test_reset();
      bus.in_valid = 0; bus.in_value = 0; bus.in_prime = 0;
      bus.frame_flush = 0; bus.out_ready = 0;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs got ready=%b valid=%b exp ready=1 valid=0", bus.in_ready, bus.out_valid);
      end
      checks++;
      if ({bus.out_count, bus.out_run, bus.out_last, bus.out_len} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_fields got %h exp 0000",
                  {bus.out_count, bus.out_run, bus.out_last, bus.out_len});
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_full_frame();
      logic [3:0] seq[8] = '{4'd2, 4'd3, 4'd5, 4'd4, 4'd7, 4'd11, 4'd13, 4'd1};
      for (int i = 0; i < 8; i++) begin
         feed(seq[i], 1'b1);
         if (i < 7) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
               errors++;
               $display("FAIL full_early_valid sample %0d got %b exp 0", i, bus.out_valid);
            end
         end
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_latency got valid=%b ready=%b exp 1 0", bus.out_valid, bus.in_ready);
      end
      checks++;
      if ({bus.out_count, bus.out_run, bus.out_last, bus.out_len} !== {4'd6, 4'd3, 4'd13, 4'd8}) begin
         errors++;
         $display("FAIL full_fields got %h exp 63d8",
                  {bus.out_count, bus.out_run, bus.out_last, bus.out_len});
      end
      cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_release got valid=%b ready=%b exp 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < FL; i++) begin
         logic [3:0] val = 4'($urandom_range(0, 15));
         feed(val, 1'b0);
      end
      snap = {bus.out_count, bus.out_run, bus.out_last, bus.out_len};
      checks++;
      if (snap !== {e_count, e_run, e_last, e_len}) begin
         errors++;
         $display("FAIL bp_fields got %h exp %h", snap, {e_count, e_run, e_last, e_len});
      end
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
             {bus.out_count, bus.out_run, bus.out_last, bus.out_len} !== snap) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got valid=%b ready=%b fields=%h exp 1 0 %h", i,
                     bus.out_valid, bus.in_ready,
                     {bus.out_count, bus.out_run, bus.out_last, bus.out_len}, snap);
         end
      end
      cycle(1'b1, 4'd10, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release got ready=%b valid=%b exp 1 0", bus.in_ready, bus.out_valid);
      end
      // The held sample must now enter a fresh frame exactly once.
      cycle(1'b1, 4'd10, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 ||
          {bus.out_count, bus.out_run, bus.out_last, bus.out_len} !== {4'd0, 4'd0, 4'd0, 4'd1}) begin
         errors++;
         $display("FAIL bp_held_sample got valid=%b fields=%h exp 1 0001", bus.out_valid,
                  {bus.out_count, bus.out_run, bus.out_last, bus.out_len});
      end
      cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_flush();
      feed(4'd0, 1'b1);
      feed(4'd9, 1'b1);
      feed(4'd15, 1'b1);
      cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 ||
          {bus.out_count, bus.out_run, bus.out_last, bus.out_len} !== {4'd0, 4'd0, 4'd0, 4'd3}) begin
         errors++;
         $display("FAIL flush_idle got valid=%b fields=%h exp 1 0003", bus.out_valid,
                  {bus.out_count, bus.out_run, bus.out_last, bus.out_len});
      end
      cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      feed(4'd2, 1'b0);
      cycle(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 ||
          {bus.out_count, bus.out_run, bus.out_last, bus.out_len} !== {4'd2, 4'd2, 4'd3, 4'd2}) begin
         errors++;
         $display("FAIL flush_with_accept got valid=%b fields=%h exp 1 2232", bus.out_valid,
                  {bus.out_count, bus.out_run, bus.out_last, bus.out_len});
      end
      cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_empty_flush_and_reset();
      logic [3:0] seq[8] = '{4'd2, 4'd3, 4'd5, 4'd4, 4'd7, 4'd11, 4'd13, 4'd1};
      cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL empty_flush got valid=%b ready=%b exp 0 1", bus.out_valid, bus.in_ready);
      end
      for (int i = 0; i < 5; i++) feed(4'd7, 1'b1);
      bus.in_valid = 1'b0;
      bus.frame_flush = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          {bus.out_count, bus.out_run, bus.out_last, bus.out_len} !== 16'h0000) begin
         errors++;
         $display("FAIL midframe_reset got valid=%b ready=%b fields=%h exp 0 1 0000",
                  bus.out_valid, bus.in_ready,
                  {bus.out_count, bus.out_run, bus.out_last, bus.out_len});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) feed(seq[i], 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 ||
          {bus.out_count, bus.out_run, bus.out_last, bus.out_len} !== {4'd6, 4'd3, 4'd13, 4'd8}) begin
         errors++;
         $display("FAIL post_reset_frame got valid=%b fields=%h exp 1 63d8", bus.out_valid,
                  {bus.out_count, bus.out_run, bus.out_last, bus.out_len});
      end
      cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_max();
      logic [3:0] seq[8] = '{4'd13, 4'd2, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
      for (int i = 0; i < 8; i++) feed(seq[i], 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 ||
          {bus.out_count, bus.out_run, bus.out_last, bus.out_len} !== {4'd2, 4'd2, 4'd2, 4'd8}) begin
         errors++;
         $display("FAIL max_frame got valid=%b fields=%h exp 1 2228", bus.out_valid,
                  {bus.out_count, bus.out_run, bus.out_last, bus.out_len});
      end
`ifdef PRIME_MAX_EN
      checks++;
      if (bus.out_max !== 4'd13) begin
         errors++;
         $display("FAIL max_value got %0d exp 13", bus.out_max);
      end
`endif
      cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         logic [3:0] val = 4'($urandom_range(0, 15));
         bit v    = ($urandom_range(0, 3) != 0);
         bit p    = is_prime(val) ^ ($urandom_range(0, 7) == 0);
         bit fl   = ($urandom_range(0, 9) == 0);
         bit ordy = ($urandom_range(0, 2) != 0);
         cycle(v, val, p, fl, ordy);
         checks++;
         if (bus.out_valid !== m_report || bus.in_ready !== !m_report) begin
            errors++;
            $display("FAIL rand_hs cycle %0d got valid=%b ready=%b exp valid=%b ready=%b", n,
                     bus.out_valid, bus.in_ready, m_report, !m_report);
         end
         if (m_report) begin
            checks++;
            if ({bus.out_count, bus.out_run, bus.out_last, bus.out_len} !==
                {e_count, e_run, e_last, e_len}) begin
               errors++;
               $display("FAIL rand_fields cycle %0d got %h exp %h", n,
                        {bus.out_count, bus.out_run, bus.out_last, bus.out_len},
                        {e_count, e_run, e_last, e_len});
            end
`ifdef PRIME_MAX_EN
            checks++;
            if (bus.out_max !== e_max) begin
               errors++;
               $display("FAIL rand_max cycle %0d got %0d exp %0d", n, bus.out_max, e_max);
            end
`endif
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_flush();
      test_empty_flush_and_reset();
      test_max();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
